spi_slave: RTL and testbench
============================

# spi_slave

SPI responder: the slave-side counterpart of the team's SPI master shift register, mode 0 (CPOL = 0, CPHA = 0), LSB first, DATA_W-bit words. It oversamples SCLK, CS and MOSI on the local system clock, so no SPI-domain flops are needed. It offers a buffered transmit byte and a received-byte strobe to local logic, and supports back-to-back words within one CS frame.

## Interface
- DATA_W, 8, word length in bits
- SYNC_STAGES, 2, synchronizer depth on SCLK, CS and MOSI (≥2)
- clkSeq  input  1  system clock; all logic is on its rising edge
- rst_n  input  1  synchronous, active-low reset
- SCLK  input  1  SPI clock from master, idle low
- CS  input  1  chip select, active low; high = deselected
- MOSI  input  1  serial data from master
- MISO  output  1  serial data to master; 1'bz whenever the synchronized CS is high
- tx_data  input  DATA_W  word to transmit
- tx_load  input  1  write strobe for tx_data; accepted only when tx_ready = 1
- tx_ready  output  1  transmit holding register empty
- rx_data  output  DATA_W  last completed received word
- rx_valid  output  1  one-cycle pulse, rx_data updated
- busy  output  1  frame in progress (synchronized CS low)
- frame_err  output  1  one-cycle pulse: CS deasserted mid-word

## Operation
- Reset (rst_n = 0 at a clkSeq edge): rx_data = 0, rx_valid = 0, tx_ready = 1, busy = 0, frame_err = 0, MISO = z, bit counter = 0, state IDLE. Synchronizers reset to SCLK = 0, CS = 1, MOSI = 0.
- Inputs pass through SYNC_STAGES flops and one further edge-detect flop. rise/fall strobes come from the last two stages.
- Holding register: tx_load with tx_ready = 1 captures tx_data and clears tx_ready. tx_load with tx_ready = 0 is ignored and the held value is kept.
- States:
  - IDLE: synchronized CS high.
  - SHIFT: CS low, word in progress.
  - Transitions: IDLE→SHIFT on CS fall. SHIFT→IDLE on CS rise.
- Word load (on CS fall, and on the 8th SCLK fall of a word while CS stays low):
  - tx shift register ← holding register if tx_ready = 0, then tx_ready ← 1.
  - Otherwise the shift register ← 0.
  - MISO ← shift bit 0 in the same cycle.
- SCLK rise in SHIFT: rx shift register shifts right, MOSI into the MSB. Bit counter increments.
- Counter reaching DATA_W (on the same rise):
  - rx_data ← assembled word, rx_valid pulses.
  - Counter wraps to 0.
- SCLK fall in SHIFT, not a word boundary: tx shift register shifts right, MISO ← new bit 0.
- CS rise with counter ≠ 0: partial word discarded, rx_data unchanged, frame_err pulses. The holding register is not consumed.
- CS rise with counter = 0: no error. MISO ← z the same cycle busy falls.
- SCLK edges while in IDLE are ignored.
- tx_load in the same cycle as a word load:
  - If tx_ready = 1 at that cycle, the load uses the old (empty) state and sends 0.
  - The new data is captured for the next word.

## Timing
- Pin-to-strobe latency: SYNC_STAGES + 1 clkSeq cycles (3 at default).
- SCLK high and low times must each be ≥ SYNC_STAGES + 2 clkSeq periods. CS setup to the first SCLK rise must meet the same minimum.
- MISO update: SYNC_STAGES + 2 cycles after the SCLK fall pin edge. After CS falls, MISO holds bit 0 from that latency onward.
- rx_valid: SYNC_STAGES + 2 cycles after the DATA_W-th SCLK rise, high exactly 1 cycle.
- tx_ready rises 1 cycle after the word load consumes the holding register.
- rst_n low mid-frame: full reset next edge, no rx_valid, no frame_err. After reset, the first frame starts only on a fresh CS fall.

## Test plan
- Single word: tx_load 0xA5, then master sends 0x3C LSB first with SCLK = 8 clkSeq/bit. Required: master receives 0xA5; rx_data = 0x3C with one rx_valid; tx_ready returns to 1.
- Back-to-back: 0x11 preloaded, 0x22 loaded after the first word load; master sends 0x81, 0x7E in one CS frame. Required: MISO carries 0x11 then 0x22; two rx_valid pulses with 0x81 then 0x7E.
- Underrun: no tx_load, master sends 0xFF. Required: master receives 0x00; rx_data = 0xFF.
- Abort: CS rises after 5 bits. Required: frame_err one pulse, no rx_valid, rx_data unchanged, MISO = z; the next frame of 0x5A is received correctly.
- Reset mid-frame: rst_n low for 2 cycles after bit 3. Required: all outputs at reset values, MISO = z; the new frame after a CS toggle is correct.
- Ignored load: second tx_load (0x99) while tx_ready = 0 after loading 0x42. Required: 0x42 is transmitted.

Source files
------------

// File: rtl/spi_slave.sv
// Mode-0, LSB-first SPI responder. SCLK, CS and MOSI are oversampled on clkSeq,
// so every flop in this block lives in the single clkSeq domain.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clkSeq,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   cs_q;
  logic [SYNC_STAGES:0]   fill;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   settled;

  logic                   armed;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_W-2:0]      rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-1:0]      hold;

  logic                   cs_start;
  logic                   boundary_fall;
  logic                   word_load;

  always_ff @(posedge clkSeq) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;
  // The synchronizers reset to CS high, so a pin already low at reset release
  // looks like a fall; frames are only accepted once CS has really been seen high.
  assign settled   = fill[SYNC_STAGES];

  assign cs_start      = (state == IDLE) && armed && cs_fall;
  assign boundary_fall = (state == SHIFT) && !cs_rise && sclk_fall && (cnt == '0);
  assign word_load     = cs_start || boundary_fall;

  always_ff @(posedge clkSeq) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tx_shift  <= '0;
      hold      <= '0;
      tx_ready  <= 1'b1;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (settled && cs_q) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (cnt == CNT_W'(DATA_W - 1)) begin
              rx_data  <= {mosi_s, rx_shift};
              rx_valid <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
            rx_shift <= {mosi_s, rx_shift[DATA_W-2:1]};
          end else if (sclk_fall && (cnt != '0)) begin
            tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A load with nothing held sends zeros; a same-cycle tx_load is then
      // captured below and kept for the following word.
      if (word_load) begin
        tx_shift <= tx_ready ? '0 : hold;
      end
      if (word_load && !tx_ready) begin
        tx_ready <= 1'b1;
      end
      if (tx_load && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  assign MISO = busy ? tx_shift[0] : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized SPI-master bench for spi_slave; a reference model of the transmit
// holding register predicts MISO words and a monitor scores every rx_valid.
module tb_spi_slave;

  logic       clkSeq = 1'b0;
  logic       rst_n = 1'b0;
  logic       SCLK = 1'b0;
  logic       CS = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  wire        MISO;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  always #5 clkSeq = ~clkSeq;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clkSeq   (clkSeq),
    .rst_n    (rst_n),
    .SCLK     (SCLK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one-deep holding register plus expected received words.
  bit         hold_full = 1'b0;
  logic [7:0] hold_val = 8'h00;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] cur_tx = 8'h00;
  logic [7:0] got = 8'h00;
  logic [7:0] rx_exp_q[$];
  int         fe_exp = 0;
  int         fe_seen = 0;
  logic       rx_valid_d = 1'b0;
  logic       frame_err_d = 1'b0;

  logic [7:0] words[4];
  int         loadBit[4];
  logic [7:0] loadVal[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every rx_valid pops the oldest expected word.
  always @(negedge clkSeq) begin
    if (rst_n) begin
      if (rx_valid) begin
        checkOutput("rx_valid_width", {31'b0, rx_valid_d}, 32'd0);
        if (rx_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rx_unexpected: actual=%0h required=no word at %0t", rx_data, $time);
        end else begin
          checkOutput("rx_data", {24'b0, rx_data}, {24'b0, rx_exp_q.pop_front()});
        end
      end
      if (frame_err) begin
        fe_seen++;
        checkOutput("frame_err_width", {31'b0, frame_err_d}, 32'd0);
      end
    end
    rx_valid_d  = rx_valid;
    frame_err_d = frame_err;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkSeq);
    #1;
  endtask

  task automatic consumeHold(output logic [7:0] v);
    v = hold_full ? hold_val : 8'h00;
    hold_full = 1'b0;
  endtask

  task automatic doLoad(input logic [7:0] d);
    checkOutput("tx_ready", {31'b0, tx_ready}, {31'b0, ~hold_full});
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    if (!hold_full) begin
      hold_full = 1'b1;
      hold_val  = d;
    end
  endtask

  task automatic startFrame();
    consumeHold(cur_tx);
    got = 8'h00;
    CS = 1'b0;
    tick(6);
  endtask

  task automatic sendBit(input logic b, input int idx);
    MOSI = b;
    tick(4);
    got[idx] = MISO;
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w, input int nbits, input int lb, input logic [7:0] lv);
    if (nbits == 8) begin
      rx_exp_q.push_back(w);
    end
    for (int i = 0; i < nbits; i++) begin
      sendBit(w[i], i);
      if (i == lb) doLoad(lv);
    end
    if (nbits == 8) begin
      checkOutput("miso_word", {24'b0, got}, {24'b0, cur_tx});
      last_rx = w;
      consumeHold(cur_tx);
    end
  endtask

  task automatic endFrame(input bit aborted);
    tick(4);
    CS = 1'b1;
    if (aborted) fe_exp++;
    tick(8);
    checkOutput("busy_idle", {31'b0, busy}, 32'd0);
    checkOutput("miso_z", {31'b0, MISO}, {31'b0, 1'bz});
    checkOutput("rx_data_hold", {24'b0, rx_data}, {24'b0, last_rx});
    checkOutput("frame_err_count", fe_seen, fe_exp);
    checkOutput("tx_ready_idle", {31'b0, tx_ready}, {31'b0, ~hold_full});
  endtask

  task automatic applyStimulus(input int nwords, input int lastBits);
    startFrame();
    for (int w = 0; w < nwords; w++) begin
      sendWord(words[w], (w == nwords - 1) ? lastBits : 8, loadBit[w], loadVal[w]);
    end
    endFrame(lastBits != 8);
  endtask

  task automatic clearPlan();
    for (int i = 0; i < 4; i++) begin
      words[i]   = 8'h00;
      loadBit[i] = -1;
      loadVal[i] = 8'h00;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_data"}, {24'b0, rx_data}, 32'd0);
    checkOutput({tag, "_rx_valid"}, {31'b0, rx_valid}, 32'd0);
    checkOutput({tag, "_tx_ready"}, {31'b0, tx_ready}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    checkOutput({tag, "_miso"}, {31'b0, MISO}, {31'b0, 1'bz});
  endtask

  initial begin
    int nw;
    int lb;
    tick(3);
    checkResetState("reset");
    rst_n = 1'b1;
    tick(8);

    // Single word
    clearPlan();
    doLoad(8'hA5);
    words[0] = 8'h3C;
    applyStimulus(1, 8);

    // Back-to-back, second word loaded during the first
    clearPlan();
    doLoad(8'h11);
    words[0] = 8'h81; loadBit[0] = 3; loadVal[0] = 8'h22;
    words[1] = 8'h7E;
    applyStimulus(2, 8);

    // Underrun
    clearPlan();
    words[0] = 8'hFF;
    applyStimulus(1, 8);

    // Abort after 5 bits, then a clean frame
    clearPlan();
    words[0] = 8'hC7;
    applyStimulus(1, 5);
    clearPlan();
    words[0] = 8'h5A;
    applyStimulus(1, 8);

    // Reset mid-frame after bit 3
    clearPlan();
    doLoad(8'h3E);
    startFrame();
    for (int i = 0; i < 4; i++) sendBit(i[0], i);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    hold_full = 1'b0;
    last_rx   = 8'h00;
    checkResetState("midreset");
    for (int i = 0; i < 3; i++) sendBit(1'b1, i);
    checkOutput("no_frame_after_reset", {31'b0, busy}, 32'd0);
    CS = 1'b1;
    tick(10);
    clearPlan();
    doLoad(8'h6B);
    words[0] = 8'hC3;
    applyStimulus(1, 8);

    // Ignored second load
    clearPlan();
    doLoad(8'h42);
    doLoad(8'h99);
    words[0] = 8'h24;
    applyStimulus(1, 8);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      clearPlan();
      nw = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) doLoad(8'($urandom));
      for (int w = 0; w < nw; w++) begin
        words[w] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          loadBit[w] = $urandom_range(0, 6);
          loadVal[w] = 8'($urandom);
        end
      end
      lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
      applyStimulus(nw, lb);
    end

    for (int i = 0; i < 100 && rx_exp_q.size() != 0; i++) tick(1);
    checkOutput("rx_pending", rx_exp_q.size(), 32'd0);
    checkOutput("frame_err_final", fe_seen, fe_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
